// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode sequencer: walks PC->MAR->memory->MDR->IR,
// latches the opcode fields and hands the instruction to one execute unit.
module fetch_decode_fsm #(
  parameter int         IW       = 18,
  parameter int         NOPS     = 8,
  parameter int         MEM_WAIT = 2,
  parameter logic [5:0] HALT_OP  = 6'h3F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IW-1:0]   bus_in,
  input  logic [NOPS-1:0] exec_done,
  output logic            PCOutEn,
  output logic            MARin,
  output logic            EN,
  output logic            RW,
  output logic            MDROutEn,
  output logic            IRin,
  output logic            PCinc,
  output logic            donefetch,
  output logic [NOPS-1:0] start,
  output logic [5:0]      opcode,
  output logic [5:0]      parameter1,
  output logic [5:0]      parameter2,
  output logic            halted,
  output logic            illegal
);

  localparam int OPW = (NOPS > 1) ? $clog2(NOPS) : 1;
  localparam int CW  = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MAR, S_RD, S_LDIR,
    S_DEC, S_EXEC, S_HALT, S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [OPW-1:0]  w_sel;
  logic            w_legal;
  logic            w_done;
  logic [NOPS-1:0] w_start_nxt;

  assign w_sel   = opcode[OPW-1:0];
  assign w_legal = (opcode < 6'(NOPS));
  assign w_done  = exec_done[w_sel];

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = '0;
    unique case (r_state)
      S_IDLE: if (run) w_next = S_MAR;
      S_MAR:  w_next = S_RD;
      S_RD: begin
        if (r_cnt == CW'(MEM_WAIT - 1)) w_next = S_LDIR;
        else w_cnt_nxt = r_cnt + 1'b1;
      end
      S_LDIR: w_next = S_DEC;
      S_DEC: begin
        if (w_legal)               w_next = S_EXEC;
        else if (opcode == HALT_OP) w_next = S_HALT;
        else                       w_next = S_ERR;
      end
      S_EXEC: if (w_done) w_next = run ? S_MAR : S_IDLE;
      S_HALT: w_next = S_HALT;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // opcode is already latched by DEC, so start can be decoded from it
  always_comb begin
    w_start_nxt = '0;
    if (w_next == S_EXEC) w_start_nxt = NOPS'(1) << w_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      PCOutEn    <= 1'b0;
      MARin      <= 1'b0;
      EN         <= 1'b0;
      RW         <= 1'b0;
      MDROutEn   <= 1'b0;
      IRin       <= 1'b0;
      PCinc      <= 1'b0;
      donefetch  <= 1'b0;
      start      <= '0;
      opcode     <= '0;
      parameter1 <= '0;
      parameter2 <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nxt;
      PCOutEn   <= (w_next == S_MAR);
      MARin     <= (w_next == S_MAR);
      EN        <= (w_next == S_RD);
      RW        <= (w_next == S_RD);
      MDROutEn  <= (w_next == S_LDIR);
      IRin      <= (w_next == S_LDIR);
      PCinc     <= (w_next == S_DEC);
      donefetch <= (w_next == S_DEC);
      start     <= w_start_nxt;
      halted    <= (w_next == S_HALT);
      illegal   <= (w_next == S_ERR);
      // these registers are the IR: captured as MDR is driven onto the bus
      if (w_next == S_DEC) begin
        opcode     <= bus_in[IW-1:IW-6];
        parameter1 <= bus_in[11:6];
        parameter2 <= bus_in[5:0];
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Bench for fetch_decode_fsm: directed scenarios with literal pins,
// then randomized run/bus/done/rst against a step-count model.
module tb_fetch_decode_fsm;

  localparam int IW = 18;
  localparam int NOPS = 8;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [IW-1:0] bus_in = '0;
  logic [NOPS-1:0] exec_done = '0;

  logic PCOutEn, MARin, EN, RW, MDROutEn, IRin, PCinc, donefetch;
  logic [NOPS-1:0] start;
  logic [5:0] opcode, parameter1, parameter2;
  logic halted, illegal;

  fetch_decode_fsm #(.IW(IW), .NOPS(NOPS), .MEM_WAIT(MW), .HALT_OP(6'h3F)) dut (
    .clk(clk), .rst(rst), .run(run), .bus_in(bus_in),
    .exec_done(exec_done), .PCOutEn(PCOutEn), .MARin(MARin),
    .EN(EN), .RW(RW), .MDROutEn(MDROutEn), .IRin(IRin),
    .PCinc(PCinc), .donefetch(donefetch), .start(start),
    .opcode(opcode), .parameter1(parameter1),
    .parameter2(parameter2), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [35:0] vec;
  assign vec = {PCOutEn, MARin, EN, RW, MDROutEn, IRin, PCinc,
                donefetch, start, opcode, parameter1, parameter2,
                halted, illegal};

  // mode: 0 idle, 1 fetching (step k from 1), 2 exec, 3 halt, 4 error
  int m_mode = 0;
  int m_k = 0;
  logic [5:0] m_op = '0, m_p1 = '0, m_p2 = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [35:0] model_out();
    logic f1, frd, fld, fdec;
    logic [7:0] st;
    f1   = (m_mode == 1) && (m_k == 1);
    frd  = (m_mode == 1) && (m_k >= 2) && (m_k <= MW + 1);
    fld  = (m_mode == 1) && (m_k == MW + 2);
    fdec = (m_mode == 1) && (m_k == MW + 3);
    st   = (m_mode == 2) ? (8'd1 << m_op[2:0]) : 8'd0;
    return {f1, f1, frd, frd, fld, fld, fdec, fdec, st,
            m_op, m_p1, m_p2, m_mode == 3, m_mode == 4};
  endfunction

  task automatic model_step(input logic r, input logic rn,
                            input logic [IW-1:0] b, input logic [7:0] d);
    if (r) begin
      m_mode = 0; m_k = 0; m_op = '0; m_p1 = '0; m_p2 = '0;
    end else begin
      case (m_mode)
        0: if (rn) begin m_mode = 1; m_k = 1; end
        1: begin
          if (m_k == MW + 3) begin
            if (m_op < NOPS) m_mode = 2;
            else if (m_op == 6'h3F) m_mode = 3;
            else m_mode = 4;
          end else begin
            if (m_k == MW + 2) begin
              m_op = b[17:12]; m_p1 = b[11:6]; m_p2 = b[5:0];
            end
            m_k++;
          end
        end
        2: if (d[m_op[2:0]]) begin
          if (rn) begin m_mode = 1; m_k = 1; end
          else m_mode = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic rn,
                      input logic [IW-1:0] b, input logic [7:0] d);
    rst = r; run = rn; bus_in = b; exec_done = d;
    model_step(r, rn, b, d);
    @(negedge clk);
    chk("cycle", 64'(vec), 64'(model_out()));
  endtask

  function automatic logic [IW-1:0] rand_bus();
    int c;
    logic [5:0] op;
    logic [11:0] f;
    c = $urandom_range(0, 9);
    if (c < 7) op = 6'($urandom_range(0, 7));
    else if (c == 7) op = 6'h3F;
    else op = 6'($urandom_range(8, 62));
    f = 12'($urandom);
    return {op, f};
  endfunction

  initial begin
    logic [IW-1:0] b;
    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    chk("reset_all_zero", 64'(vec), 64'd0);

    b = 18'h01042;
    step(0, 1, b, '0);
    chk("t1_marin", 64'(MARin), 64'd1);
    step(0, 1, b, '0);
    chk("t2_en", 64'({EN, RW}), 64'd3);
    step(0, 1, b, '0);
    chk("t3_en", 64'({EN, RW}), 64'd3);
    step(0, 1, b, '0);
    chk("t4_irin", 64'(IRin), 64'd1);
    step(0, 1, b, '0);
    chk("t5_donefetch", 64'({donefetch, PCinc}), 64'd3);
    chk("t5_fields", 64'({opcode, parameter1, parameter2}), 64'h01042);
    step(0, 1, b, '0);
    chk("t6_start", 64'(start), 64'h02);
    step(0, 1, b, 8'h01);
    chk("wrong_done_ignored", 64'(start), 64'h02);
    step(0, 1, b, 8'h02);
    chk("done_start_drop", 64'(start), 64'h00);
    chk("done_marin", 64'(MARin), 64'd1);

    repeat (5) step(0, 1, b, '0);
    chk("exec_again", 64'(start), 64'h02);
    step(0, 0, b, '0);
    step(0, 0, b, 8'h02);
    chk("idle_after_run0", 64'({MARin, start}), 64'd0);
    repeat (3) begin
      step(0, 0, b, '0);
      chk("idle_stays", 64'(MARin), 64'd0);
    end

    b = 18'h3F000;
    repeat (6) step(0, 1, b, '0);
    chk("halt_set", 64'({halted, start}), 64'h100);
    repeat (3) begin
      step(0, 1, b, 8'hFF);
      chk("halt_stuck", 64'({halted, MARin}), 64'd2);
    end
    step(1, 1, b, '0);
    chk("halt_rst", 64'(halted), 64'd0);

    b = 18'h0A000;
    step(0, 1, b, '0);
    step(0, 1, b, '0);
    chk("midrd_en", 64'(EN), 64'd1);
    step(1, 1, b, '0);
    step(1, 1, b, '0);
    chk("midrd_rst_zero", 64'(vec), 64'd0);
    step(0, 1, b, '0);
    chk("restart_marin", 64'(MARin), 64'd1);
    repeat (5) step(0, 1, b, '0);
    chk("illegal_set", 64'({illegal, start}), 64'h100);
    step(1, 0, b, '0);
    chk("illegal_rst", 64'(illegal), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      logic r, rn;
      logic [7:0] d;
      if (m_mode >= 3) r = ($urandom_range(0, 3) == 0);
      else r = ($urandom_range(0, 99) == 0);
      rn = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      step(r, rn, rand_bus(), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
